si_channel_arbiter: RTL
=======================

Name: si_channel_arbiter

Overview:
- Merges N independent tag streams into one tag stream, e.g. several si_data_channel outputs from multiple SFP+ links feeding one downstream tag processor.
- Arbitration is packet-atomic round-robin: a granted channel keeps the output until its tlast beat.
- Output beats carry the source channel index and the per-packet rollover time (tuser).
- Output is registered through a 2-entry skid buffer for timing closure.

Parameters:
- NUM_CHANNELS, 4, number of input streams (1..16).
- DATA_WIDTH, 32, tag beat width; must be a multiple of 32.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 32, tuser width (rollover time).
- ID_WIDTH, max(1, clog2(NUM_CHANNELS)), width of m_axis_tid.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-low.
- enable_mask  in  NUM_CHANNELS  per-channel arbitration enable.
- s_axis_tvalid  in  NUM_CHANNELS  per-channel valid.
- s_axis_tready  out  NUM_CHANNELS  per-channel ready.
- s_axis_tdata  in  NUM_CHANNELS*DATA_WIDTH  packed data; channel i is at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  NUM_CHANNELS*KEEP_WIDTH  packed keep.
- s_axis_tlast  in  NUM_CHANNELS  per-channel last.
- s_axis_tuser  in  NUM_CHANNELS*USER_WIDTH  packed rollover time.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  output keep.
- m_axis_tlast  out  1  output last.
- m_axis_tuser  out  USER_WIDTH  output rollover time.
- m_axis_tid  out  ID_WIDTH  source channel index.
- stat_sel  in  ID_WIDTH+1  statistics select (see Optional Feature).
- stat_data  out  32  statistics readback.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; round-robin pointer = 0; grant = 0.
  - Skid buffer is emptied; m_axis_tvalid = 0; all s_axis_tready = 0.
  - m_axis_tdata/tkeep/tlast/tuser/tid = 0; stat_data = 0.
- FSM, IDLE:
  - Candidates are channels i with s_axis_tvalid[i] & enable_mask[i].
  - Search starts at the pointer and wraps modulo NUM_CHANNELS; the first candidate found is registered as grant.
  - If a candidate exists, next state is BUSY; otherwise stay in IDLE.
  - All s_axis_tready are 0 in IDLE.
- FSM, BUSY:
  - s_axis_tready[grant] = skid buffer not full; all other readies are 0.
  - Each handshake pushes {tdata, tkeep, tlast, tuser, grant} into the skid buffer.
  - A handshake with tlast=1 returns the FSM to IDLE and sets pointer = (grant+1) mod NUM_CHANNELS.
  - The grant never changes mid-packet. enable_mask changes and tvalid gaps mid-packet are ignored until tlast.
- Throughput: one IDLE cycle per packet (arbitration bubble); full rate within a packet.
- Latency:
  - First beat: s_axis_tvalid high → arbitration (1 cycle) → beat accepted in the BUSY cycle → m_axis_tvalid high the cycle after acceptance.
  - Input handshake to m_axis_tvalid: 1 cycle.
- Skid buffer:
  - 2 entries, FIFO order, no bubbles.
  - Full = 2 entries held; s_axis_tready[grant] deasserts when full.
  - Simultaneous push and pop while full is not possible, because ready is low.
  - Simultaneous push and pop with 1 entry keeps the count at 1.
  - Outputs come from the head entry; hold steady while m_axis_tvalid & !m_axis_tready (AXIS-compliant).
- NUM_CHANNELS=1: the FSM still runs; m_axis_tid is always 0.
- No data is reordered, dropped or duplicated under any tready pattern.

Optional Feature:
- Macro: SI_CHANNEL_ARBITER_STATS_EN.
- Defined:
  - Per-channel 32-bit packet counters, incremented on each tlast output handshake (m_axis_tvalid & m_axis_tready & tlast) for the tid of that beat.
  - One 32-bit grant-stall counter, incremented every BUSY cycle with s_axis_tvalid[grant]=0.
  - stat_sel < NUM_CHANNELS selects a packet counter; stat_sel = NUM_CHANNELS selects the stall counter; any other value reads 0.
  - stat_data is registered, 1-cycle read latency.
  - Counters wrap at 2^32 and clear on reset.
- Undefined: no counters are implemented; stat_data is tied to 0.

Test Plan:
1. Single channel: ch0 sends a 4-beat packet, tuser=0x12345678, m_axis_tready=1 → 4 output beats, tid=0, tlast on beat 4, tuser=0x12345678 on all beats, first m_axis_tvalid 2 cycles after s_axis_tvalid[0] rises.
2. Simultaneous requests: all 4 channels hold 2-beat packets from reset release, mask=0xF → output tid sequence 0,0,1,1,2,2,3,3; tlast on every 2nd beat; no interleaving.
3. Fairness: ch0 and ch2 request continuously (3-beat packets) → packets alternate tid 0,2,0,2…; ch1/ch3 never appear.
4. Backpressure: ch1 sends 8 beats with data 1..8 while m_axis_tready toggles 1,0 → output 1..8 in order, no loss or duplicates, output held stable while tready=0.
5. Async reset: rst low during beat 3 of a 6-beat packet → m_axis_tvalid=0 and all s_axis_tready=0 in the same cycle; after release, pointer=0 and ch0 wins when ch0 and ch3 request.
6. Mask mid-packet: clear enable_mask[1] during beat 2 of a 5-beat ch1 packet → all 5 beats complete; ch1 is not granted again. With SI_CHANNEL_ARBITER_STATS_EN defined, stat_sel=1 reads 1.

Source files
------------

// File: rtl/si_channel_arbiter.sv
// si_channel_arbiter: packet-atomic round-robin merge of NUM_CHANNELS AXI-Stream
// tag streams into one. The output carries the source index (tid) and the
// rollover time (tuser), and is registered through a 2-entry skid buffer.
// Optional build macro SI_CHANNEL_ARBITER_STATS_EN adds per-channel packet
// counters and a grant-stall counter, read through stat_sel/stat_data.

`ifdef SI_CHANNEL_ARBITER_STATS_EN
// Wrapping 32-bit event counter, one per statistic.
module si_channel_arbiter_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);
  // Count events; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst)
    if (!rst)     count <= '0;
    else if (inc) count <= count + 32'd1;
endmodule
`endif

module si_channel_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = DATA_WIDTH/8,
  parameter int USER_WIDTH   = 32,
  parameter int ID_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CHANNELS-1:0]            enable_mask,
  input  logic [NUM_CHANNELS-1:0]            s_axis_tvalid,
  output logic [NUM_CHANNELS-1:0]            s_axis_tready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CHANNELS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_CHANNELS-1:0]            s_axis_tlast,
  input  logic [NUM_CHANNELS*USER_WIDTH-1:0] s_axis_tuser,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]              m_axis_tkeep,
  output logic                               m_axis_tlast,
  output logic [USER_WIDTH-1:0]              m_axis_tuser,
  output logic [ID_WIDTH-1:0]                m_axis_tid,
  input  logic [ID_WIDTH:0]                  stat_sel,
  output logic [31:0]                        stat_data
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
    logic [ID_WIDTH-1:0]   id;
  } beat_t;

  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] s_data;
  logic [NUM_CHANNELS-1:0][KEEP_WIDTH-1:0] s_keep;
  logic [NUM_CHANNELS-1:0][USER_WIDTH-1:0] s_user;

  assign s_data = s_axis_tdata;
  assign s_keep = s_axis_tkeep;
  assign s_user = s_axis_tuser;

  state_t                state, state_nxt;
  logic [ID_WIDTH-1:0]   grant, ptr, pick, ptr_nxt;
  logic                  found, g_valid, push, pop, full;
  beat_t                 in_beat, head;
  beat_t                 mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            cnt;
  logic [2*NUM_CHANNELS-1:0] rot;

  // Rotate the candidate set so the search starts at ptr; lowest offset wins.
  always_comb begin
    int sum;
    sum   = 0;
    found = 1'b0;
    pick  = '0;
    rot   = {s_axis_tvalid & enable_mask, s_axis_tvalid & enable_mask} >> ptr;
    for (int k = NUM_CHANNELS-1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum   = int'(ptr) + k;
        if (sum >= NUM_CHANNELS) sum = sum - NUM_CHANNELS;
        pick  = ID_WIDTH'(sum);
      end
    end
  end

  // Mux the granted channel's beat onto the skid-buffer write port.
  always_comb begin
    in_beat = '0;
    g_valid = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (int'(grant) == i) begin
        g_valid      = s_axis_tvalid[i];
        in_beat.data = s_data[i];
        in_beat.keep = s_keep[i];
        in_beat.last = s_axis_tlast[i];
        in_beat.user = s_user[i];
      end
    end
    in_beat.id = grant;
  end

  assign full    = (cnt == 2'd2);
  assign push    = (state == BUSY) && g_valid && !full;
  assign pop     = m_axis_tvalid && m_axis_tready;
  assign ptr_nxt = (int'(grant) == NUM_CHANNELS-1) ? '0 : grant + ID_WIDTH'(1);

  // FSM state register plus the grant and round-robin pointer it owns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) grant <= pick;
      if (push && in_beat.last)   ptr   <= ptr_nxt;
    end
  end

  // Next state: grant on any candidate, release only on the accepted tlast beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (found)                 state_nxt = BUSY;
      BUSY: if (push && in_beat.last)  state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Outputs: only the granted channel sees ready, and only while there is room.
  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      s_axis_tready[i] = (state == BUSY) && (int'(grant) == i) && !full;
  end

  // Two-entry skid FIFO; ready never depends on m_axis_tready combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_beat;
        wr_ptr      <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      if (push && !pop)      cnt <= cnt + 2'd1;
      else if (pop && !push) cnt <= cnt - 2'd1;
    end
  end

  assign head          = mem[rd_ptr];
  assign m_axis_tvalid = (cnt != 2'd0);
  assign m_axis_tdata  = head.data;
  assign m_axis_tkeep  = head.keep;
  assign m_axis_tlast  = head.last;
  assign m_axis_tuser  = head.user;
  assign m_axis_tid    = head.id;

`ifdef SI_CHANNEL_ARBITER_STATS_EN
  logic [NUM_CHANNELS-1:0][31:0] pkt_cnt;
  logic [31:0]                   stall_cnt, sel_val;
  logic                          stall_inc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_pkt
      si_channel_arbiter_ctr u_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (pop && m_axis_tlast && (m_axis_tid == ID_WIDTH'(gi))),
        .count (pkt_cnt[gi])
      );
    end
  endgenerate

  assign stall_inc = (state == BUSY) && !g_valid;

  si_channel_arbiter_ctr u_stall_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  // Readback select: packet counters, then the stall counter, else zero.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (int'(stat_sel) == i) sel_val = pkt_cnt[i];
    if (int'(stat_sel) == NUM_CHANNELS) sel_val = stall_cnt;
  end

  // Registered readback, one cycle of latency.
  always_ff @(posedge clk or negedge rst)
    if (!rst) stat_data <= '0;
    else      stat_data <= sel_val;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_data       = '0;
`endif

endmodule
